// File: rtl/prefetch_if.sv
// Fetch-side and decode-side handshake bundle for prefetch_queue.
// The master modport belongs to the environment (fetch unit plus decoder); the slave modport belongs to the queue.
interface prefetch_if #(
   parameter int INST_W  = 16,
   parameter int FETCH_N = 2,
   parameter int DEPTH   = 8,
   parameter int PC_W    = 32
);
   logic                        fetch_valid;
   logic [FETCH_N*INST_W-1:0]   fetch_data;
   logic [PC_W-1:0]             fetch_pc;
   logic                        fetch_ready;
   logic                        flush;
   logic                        inst_valid;
   logic [INST_W-1:0]           inst;
   logic [PC_W-1:0]             inst_pc;
   logic                        inst_ready;
   logic [$clog2(DEPTH):0]      count;

   modport master (
      output fetch_valid, fetch_data, fetch_pc, flush, inst_ready,
      input  fetch_ready, inst_valid, inst, inst_pc, count
   );

   modport slave (
      input  fetch_valid, fetch_data, fetch_pc, flush, inst_ready,
      output fetch_ready, inst_valid, inst, inst_pc, count
   );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: accepts FETCH_N-lane fetch words and delivers one instruction per pop.
// Defining PREFETCH_BYPASS_EN lets an empty queue present lane 0 of the incoming word in the same cycle.
module prefetch_queue #(
   parameter int INST_W  = 16,
   parameter int FETCH_N = 2,
   parameter int DEPTH   = 8,
   parameter int PC_W    = 32
) (
   input logic        clk,
   input logic        rst,
   prefetch_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - FETCH_N);

   logic [INST_W-1:0] mem_inst [DEPTH];
   logic [PC_W-1:0]   mem_pc   [DEPTH];
   logic [AW-1:0]     head, tail;
   logic [CW-1:0]     cnt;

   logic              push, q_pop, wr_skip;
   logic [CW-1:0]     push_n;

   assign bus.fetch_ready = (cnt <= READY_MAX);
   assign bus.count       = cnt;
   assign push            = bus.fetch_valid && bus.fetch_ready && !bus.flush;
   assign q_pop           = (cnt != '0) && bus.inst_ready;
   assign push_n          = push ? (CW'(FETCH_N) - CW'(wr_skip)) : '0;

`ifdef PREFETCH_BYPASS_EN
   logic byp;
   assign byp = (cnt == '0) && !bus.flush && bus.fetch_valid;
`endif

   always_comb begin
      bus.inst_valid = (cnt != '0);
      bus.inst       = mem_inst[head];
      bus.inst_pc    = mem_pc[head];
      wr_skip        = 1'b0;
`ifdef PREFETCH_BYPASS_EN
      // A popped bypass lane is consumed directly, so lane 0 is never stored.
      if (byp) begin
         bus.inst_valid = 1'b1;
         bus.inst       = bus.fetch_data[INST_W-1:0];
         bus.inst_pc    = bus.fetch_pc;
         wr_skip        = bus.inst_ready;
      end
`endif
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < FETCH_N; k++) begin
         if (push && !(wr_skip && k == 0)) begin
            mem_inst[tail + AW'(k) - AW'(wr_skip)] <= bus.fetch_data[k*INST_W +: INST_W];
            mem_pc[tail + AW'(k) - AW'(wr_skip)]   <= bus.fetch_pc + PC_W'(k * (INST_W / 8));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (bus.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (q_pop) head <= head + 1'b1;
         tail <= tail + AW'(push_n);
         cnt  <= cnt + push_n - CW'(q_pop);
      end
   end
endmodule

// File: tb/tb_prefetch_queue.sv
// Directed self-checking bench for prefetch_queue (INST_W 16, FETCH_N 2, DEPTH 8, PC_W 32).
// Expectations follow the PREFETCH_BYPASS_EN setting of the build.
module tb_prefetch_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   prefetch_if #(.INST_W(16), .FETCH_N(2), .DEPTH(8), .PC_W(32)) bus ();

   prefetch_queue #(.INST_W(16), .FETCH_N(2), .DEPTH(8), .PC_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fv, input logic [31:0] d, input logic [31:0] pc,
                        input logic ir, input logic fl);
      bus.fetch_valid = fv;
      bus.fetch_data  = d;
      bus.fetch_pc    = pc;
      bus.inst_ready  = ir;
      bus.flush       = fl;
   endtask

   logic [15:0] q_inst [$];
   logic [31:0] q_pc   [$];

   initial begin
      logic [15:0] hi, lo, e_inst;
      logic [31:0] e_pc;
      logic        e_ready, e_valid, use_byp;
      int          k;

      drive(1'b0, '0, '0, 1'b0, 1'b0);

      // reset state
      step();
      step();
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
      rst = 1'b0;

      // pop while empty has no effect
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      check("empty_pop_count", 32'(bus.count), 32'd0);
      check("empty_pop_valid", 32'(bus.inst_valid), 32'd0);

      // bypass / latency on an empty queue
      drive(1'b1, 32'h2222_1111, 32'h40, 1'b1, 1'b0);
      #1;
      check("byp_same_valid", 32'(bus.inst_valid), 32'(BYP));
      if (BYP) begin
         check("byp_same_inst", 32'(bus.inst), 32'h1111);
         check("byp_same_pc", bus.inst_pc, 32'h40);
      end
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("byp_next_count", 32'(bus.count), BYP ? 32'd1 : 32'd2);
      check("byp_next_inst", 32'(bus.inst), BYP ? 32'h2222 : 32'h1111);
      check("byp_next_pc", bus.inst_pc, BYP ? 32'h42 : 32'h40);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      step();
      check("flush_clear_count", 32'(bus.count), 32'd0);

      // basic push then pop
      drive(1'b1, 32'hBBBB_AAAA, 32'h100, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("push_count", 32'(bus.count), 32'd2);
      check("push_inst", 32'(bus.inst), 32'hAAAA);
      check("push_pc", bus.inst_pc, 32'h100);
      bus.inst_ready = 1'b1;
      step();
      check("pop_inst", 32'(bus.inst), 32'hBBBB);
      check("pop_pc", bus.inst_pc, 32'h102);
      check("pop_count", 32'(bus.count), 32'd1);
      step();
      bus.inst_ready = 1'b0;
      check("drain_count", 32'(bus.count), 32'd0);

      // fill to DEPTH, hold fifth word, then pop twice
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, {16'(16'h10 + 2*i + 1), 16'(16'h10 + 2*i)}, 32'(32'h200 + 4*i), 1'b0, 1'b0);
         step();
      end
      check("full_count", 32'(bus.count), 32'd8);
      check("full_ready", 32'(bus.fetch_ready), 32'd0);
      drive(1'b1, 32'hDEAD_BEEF, 32'h400, 1'b0, 1'b0);
      step();
      check("held_count", 32'(bus.count), 32'd8);
      check("held_inst", 32'(bus.inst), 32'h10);
      check("held_pc", bus.inst_pc, 32'h200);
      bus.inst_ready = 1'b1;
      step();
      check("pop7_count", 32'(bus.count), 32'd7);
      check("pop7_ready", 32'(bus.fetch_ready), 32'd0);
      check("pop7_inst", 32'(bus.inst), 32'h11);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("pop6_count", 32'(bus.count), 32'd6);
      check("pop6_ready", 32'(bus.fetch_ready), 32'd1);
      check("pop6_pc", bus.inst_pc, 32'h204);

      // asynchronous reset between edges
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus.inst_valid), 32'd0);
      check("async_rst_count", 32'(bus.count), 32'd0);
      step();
      rst = 1'b0;

      // streaming push+pop against a FIFO model across pointer wrap
      k = 0;
      q_inst.delete();
      q_pc.delete();
      for (int c = 0; c < 20; c++) begin
         lo = 16'(16'hC000 + 2*k);
         hi = 16'(16'hC001 + 2*k);
         drive(1'b1, {hi, lo}, 32'(32'h300 + 4*k), 1'b1, 1'b0);
         #1;
         e_ready = (8 - q_inst.size()) >= 2;
         use_byp = BYP && q_inst.size() == 0;
         e_valid = use_byp || q_inst.size() != 0;
         check("stream_ready", 32'(bus.fetch_ready), 32'(e_ready));
         check("stream_valid", 32'(bus.inst_valid), 32'(e_valid));
         if (e_valid) begin
            e_inst = use_byp ? lo : q_inst[0];
            e_pc   = use_byp ? 32'(32'h300 + 4*k) : q_pc[0];
            check("stream_inst", 32'(bus.inst), 32'(e_inst));
            check("stream_pc", bus.inst_pc, e_pc);
         end
         if (use_byp) begin
            q_inst.push_back(hi);
            q_pc.push_back(32'(32'h302 + 4*k));
         end else begin
            if (e_valid) begin
               void'(q_inst.pop_front());
               void'(q_pc.pop_front());
            end
            if (e_ready) begin
               q_inst.push_back(lo);
               q_pc.push_back(32'(32'h300 + 4*k));
               q_inst.push_back(hi);
               q_pc.push_back(32'(32'h302 + 4*k));
            end
         end
         if (e_ready) k++;
         step();
         check("stream_count", 32'(bus.count), 32'(q_inst.size()));
      end

      // flush overrides simultaneous push and pop at count 5
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h5555_4444, 32'h500, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      check("pre_flush_count", 32'(bus.count), 32'd5);
      drive(1'b1, 32'h7777_6666, 32'h600, 1'b1, 1'b1);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("flush_count", 32'(bus.count), 32'd0);
      check("flush_valid", 32'(bus.inst_valid), 32'd0);
      check("flush_ready", 32'(bus.fetch_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL have parameter INST_W, default 16, instruction width in bits (multiple of 8).
REQ-002 SHALL have parameter FETCH_N, default 2, instructions per fetch word.
REQ-003 SHALL have parameter DEPTH, default 8, queue entries (power of 2, DEPTH >= FETCH_N).
REQ-004 SHALL have parameter PC_W, default 32, PC width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 fetch_valid  input  1  fetch word present.
REQ-008 fetch_data  input  FETCH_N*INST_W  fetch word; lane k = bits [k*INST_W +: INST_W], lane 0 first in program order.
REQ-009 fetch_pc  input  PC_W  byte PC of lane 0.
REQ-010 fetch_ready  output  1  queue can accept a full fetch word.
REQ-011 flush  input  1  discard all queued and incoming instructions (branch/jump redirect).
REQ-012 inst_valid  output  1  head entry valid.
REQ-013 inst  output  INST_W  head instruction.
REQ-014 inst_pc  output  PC_W  byte PC of head instruction.
REQ-015 inst_ready  input  1  consumer takes head (low = decode stall).
REQ-016 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Push SHALL occur when fetch_valid && fetch_ready && !flush; all FETCH_N lanes written in order at the tail in one cycle.
REQ-018 Lane k SHALL be stored with PC = fetch_pc + k*(INST_W/8), truncated to PC_W.
REQ-019 fetch_ready SHALL be combinational: (DEPTH - count) >= FETCH_N; partial-word acceptance never occurs.
REQ-020 inst_valid SHALL be (count != 0); inst/inst_pc SHALL reflect the head entry combinationally.
REQ-021 Pop SHALL occur when inst_valid && inst_ready; head advances by one.
REQ-022 Simultaneous push and pop SHALL update count by FETCH_N - 1 in one cycle.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; no entry is lost or duplicated across wrap.
REQ-024 fetch_valid while !fetch_ready SHALL leave state unchanged; the producer holds the word.
REQ-025 Pop with count == 0 SHALL have no effect.
REQ-026 flush SHALL, on the next edge, zero count and pointers, overriding any same-cycle push and pop.
REQ-027 Without the bypass, accept-to-inst_valid latency SHALL be one cycle.

Reset
REQ-028 While rst is high: head = tail = 0, count = 0, inst_valid = 0, fetch_ready = 1.
REQ-029 Reset mid-operation SHALL discard all entries immediately; storage array contents need no reset.

Configuration
REQ-030 With PREFETCH_BYPASS_EN defined: if count == 0, !flush and fetch_valid, inst_valid SHALL be 1 in the same cycle with inst = lane 0 and inst_pc = fetch_pc.
REQ-031 With PREFETCH_BYPASS_EN defined and the bypassed lane popped that cycle, only lanes 1..FETCH_N-1 SHALL be written and count SHALL become FETCH_N - 1.
REQ-032 Without PREFETCH_BYPASS_EN: no combinational path from fetch_* to inst_* or inst_valid; latency per REQ-027.

Verification
REQ-033 Reset, then push 0xBBBB_AAAA at fetch_pc 0x100 with inst_ready = 0 -> next cycle count = 2, inst = 0xAAAA, inst_pc = 0x100; after one pop inst = 0xBBBB, inst_pc = 0x102.
REQ-034 Four pushes with inst_ready = 0 (DEPTH 8) -> count = 8, fetch_ready = 0; fifth word held, state unchanged; one pop leaves fetch_ready = 0 (7 entries); a second pop raises fetch_ready.
REQ-035 Continuous push and pop for 20 cycles -> output order and PCs match input sequence across pointer wrap; count increments by 1 per cycle until full.
REQ-036 count = 5 with push, pop and flush in the same cycle -> next cycle count = 0, inst_valid = 0, fetch_ready = 1.
REQ-037 PREFETCH_BYPASS_EN defined, empty queue, push 0x2222_1111 at 0x40 with inst_ready = 1 -> same cycle inst = 0x1111, inst_pc = 0x40; next cycle count = 1, inst = 0x2222, inst_pc = 0x42. Same stimulus without the macro -> inst_valid = 0 in the push cycle.
REQ-038 rst asserted asynchronously with count = 6 -> inst_valid = 0 and count = 0 before the next clock edge.
